// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - hazard controller decode/EX inputs and pipeline-register controls
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       ID_Rs;
  logic [4:0]       ID_Rt;
  logic             ID_UsesRt;
  logic             ID_IsMul;
  logic             ID_jump;
  logic             EX_MemRead;
  logic [4:0]       EX_WriteReg;
  logic             Branch_Taken;
  logic             PC_Write;
  logic             IFID_Write;
  logic             IFID_Flush;
  logic             IDEX_Bubble;
  logic [1:0]       Ctrl_State;
  logic [CNT_W-1:0] Stall_Count;

  modport master (
    output ID_Rs, ID_Rt, ID_UsesRt, ID_IsMul, ID_jump, EX_MemRead, EX_WriteReg, Branch_Taken,
    input  PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, Ctrl_State, Stall_Count
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_UsesRt, ID_IsMul, ID_jump, EX_MemRead, EX_WriteReg, Branch_Taken,
    output PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, Ctrl_State, Stall_Count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - load-use, multiply-stall and branch-flush sequencing for IF/ID and ID/EX
module pipeline_hazard_ctrl #(
  parameter int MUL_LATENCY  = 4,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic                   Clk,
  input  logic                   Reset,
  pipeline_hazard_ctrl_if.slave  hz
);
  localparam int MAXC = (MUL_LATENCY > FLUSH_CYCLES) ? MUL_LATENCY : FLUSH_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MUL_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_q;
  logic             load_use;
  logic             pc_write, ifid_write, ifid_flush, idex_bubble;

  assign load_use = hz.EX_MemRead && (hz.EX_WriteReg != 5'd0) &&
                    ((hz.EX_WriteReg == hz.ID_Rs) ||
                     (hz.ID_UsesRt && (hz.EX_WriteReg == hz.ID_Rt)));

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    state_d     = state_q;
    cnt_d       = cnt_q;
    if (hz.Branch_Taken) begin
      // A resolved branch overrides everything, including an in-flight multiply stall.
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d = FLUSH;
        cnt_d   = CW'(FLUSH_CYCLES - 1);
      end else begin
        state_d = RUN;
      end
    end else begin
      case (state_q)
        MUL_WAIT: begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          cnt_d       = cnt_q - CW'(1);
          if (cnt_q <= CW'(1)) state_d = RUN;
        end
        FLUSH: begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          cnt_d       = cnt_q - CW'(1);
          if (cnt_q <= CW'(1)) state_d = RUN;
        end
        default: begin
          // Encoding 3 is unreachable in normal operation; it behaves as RUN and recovers.
          state_d = RUN;
          if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
          end else if (hz.ID_IsMul) begin
            if (MUL_LATENCY > 1) begin
              state_d = MUL_WAIT;
              cnt_d   = CW'(MUL_LATENCY - 1);
            end
          end else if (hz.ID_jump) begin
            ifid_flush = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (!pc_write && (stall_q != {CNT_W{1'b1}})) stall_q <= stall_q + CNT_W'(1);
    end
  end

  // Reset holds the pipeline frozen with a bubble in ID/EX regardless of inputs.
  assign hz.PC_Write    = Reset ? 1'b0 : pc_write;
  assign hz.IFID_Write  = Reset ? 1'b0 : ifid_write;
  assign hz.IFID_Flush  = Reset ? 1'b0 : ifid_flush;
  assign hz.IDEX_Bubble = Reset ? 1'b1 : idex_bubble;
  assign hz.Ctrl_State  = state_q;
  assign hz.Stall_Count = stall_q;
endmodule
